// File: rtl/imem_loader_if.sv
// Byte-stream ingress and instruction-memory write port
// bundled for the program loader.
interface imem_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: length header plus big-endian 16-bit words
// from a byte stream, written to imem at even byte addresses.
module imem_loader #(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [15:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MEM_WORDS);

    state_t            st;
    state_t            nxt;
    logic [15:0]       len_q;
    logic [7:0]        hi_q;
    logic [15:0]       cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;

    logic              take;
    logic              idle_like;
    logic [15:0]       len_full;
    logic [15:0]       cnt_inc;
    logic [ADDR_W-1:0] cnt_ext;

    assign take      = bus.in_valid & bus.in_ready;
    assign idle_like = (st == IDLE) | (st == DONE) | (st == ERROR);
    assign len_full  = {len_q[15:8], bus.in_data};
    assign cnt_inc   = cnt_q + 16'd1;
    assign cnt_ext   = ADDR_W'(cnt_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    // Next-state logic
    always_comb begin
        nxt = st;
        unique case (st)
            IDLE, DONE, ERROR: begin
                if (start) nxt = LEN_HI;
            end
            LEN_HI: begin
                if (take) nxt = LEN_LO;
            end
            LEN_LO: begin
                if (take) begin
                    unique case (1'b1)
                        (len_full == 16'd0):   nxt = DONE;
                        (len_full > MAX_LEN):  nxt = ERROR;
                        default:               nxt = DATA_HI;
                    endcase
                end
            end
            DATA_HI: begin
                if (take) nxt = DATA_LO;
            end
            DATA_LO: begin
                if (take) nxt = WRITE;
            end
            WRITE: begin
                nxt = (cnt_inc == len_q) ? DONE : DATA_HI;
            end
            default: nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        bus.in_ready = 1'b0;
        bus.mem_we   = 1'b0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        unique case (st)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO: begin
                bus.in_ready = 1'b1;
                cpu_hold     = 1'b1;
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                cpu_hold   = 1'b1;
            end
            DONE:    done  = 1'b1;
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: address/data latch on the low byte so the
    // write cycle presents them and they hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (idle_like && start) begin
                cnt_q <= '0;
            end
            if (st == LEN_HI && take) begin
                len_q[15:8] <= bus.in_data;
            end
            if (st == LEN_LO && take) begin
                len_q[7:0] <= bus.in_data;
            end
            if (st == DATA_HI && take) begin
                hi_q <= bus.in_data;
            end
            if (st == DATA_LO && take) begin
                addr_q  <= {cnt_ext[ADDR_W-2:0], 1'b0};
                wdata_q <= {hi_q, bus.in_data};
            end
            if (st == WRITE) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign word_count    = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table,
// random sessions vs a queue model, and corner sequences.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    imem_loader_if #(.ADDR_W(16)) bus ();

    imem_loader #(
        .MEM_WORDS(64),
        .ADDR_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bus(bus),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] len;
        int          mode;
        bit          fixed;
        bit          exp_done;
        bit          exp_err;
        logic [15:0] exp_wc;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] got[$];
    logic [31:0] exp[$];
    logic [15:0] words[$];
    vec_t        tbl[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.mem_we === 1'b1) begin
            got.push_back({bus.mem_addr, bus.mem_wdata});
            chk("ready_in_write", 32'(bus.in_ready), 32'd0);
            chk("hold_in_write", 32'(cpu_hold), 32'd1);
        end
    end

    function automatic int gap_of(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    // Called and returns at a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout actual=%0d required=<100", t);
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill_words(input logic [15:0] len, input bit fixed);
        words.delete();
        if (fixed) begin
            words.push_back(16'h1234);
            words.push_back(16'hABCD);
            words.push_back(16'h0FF0);
        end else begin
            for (int i = 0; i < int'(len) && i < 64; i++) begin
                words.push_back(16'($urandom));
            end
        end
    endtask

    task automatic build_exp(input logic [15:0] len);
        exp.delete();
        if (len <= 16'd64) begin
            for (int i = 0; i < int'(len); i++) begin
                exp.push_back({16'(2 * i), words[i]});
            end
        end
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_nwrites"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk({tag, "_write"}, got[i], exp[i]);
        end
    endtask

    task automatic run_session(input logic [15:0] len, input int mode,
                               input int restart_after);
        got.delete();
        pulse_start();
        chk("hold_after_start", 32'(cpu_hold), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        chk("error_cleared", 32'(error), 32'd0);
        send_byte(len[15:8], gap_of(mode));
        send_byte(len[7:0], gap_of(mode));
        if (len != 16'd0 && len <= 16'd64) begin
            for (int i = 0; i < int'(len); i++) begin
                send_byte(words[i][15:8], gap_of(mode));
                send_byte(words[i][7:0], gap_of(mode));
                if (i + 1 == restart_after) pulse_start();
            end
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        build_exp(len);
    endtask

    task automatic end_checks(input string tag, input bit e_done,
                              input bit e_err, input logic [15:0] e_wc);
        cmp_writes(tag);
        chk({tag, "_done"}, 32'(done), 32'(e_done));
        chk({tag, "_error"}, 32'(error), 32'(e_err));
        chk({tag, "_wc"}, 32'(word_count), 32'(e_wc));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        logic [15:0] rlen;
        bit          ok;

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        tbl[0] = '{16'd3,   0, 1'b1, 1'b1, 1'b0, 16'd3};
        tbl[1] = '{16'd3,   1, 1'b1, 1'b1, 1'b0, 16'd3};
        tbl[2] = '{16'd0,   0, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[3] = '{16'h41,  0, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[4] = '{16'h40,  2, 1'b0, 1'b1, 1'b0, 16'd64};
        tbl[5] = '{16'h100, 0, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[6] = '{16'd1,   2, 1'b0, 1'b1, 1'b0, 16'd1};

        #12;
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_hold", 32'(cpu_hold), 32'd0);

        for (int v = 0; v < 7; v++) begin
            fill_words(tbl[v].len, tbl[v].fixed);
            run_session(tbl[v].len, tbl[v].mode, -1);
            end_checks($sformatf("vec%0d", v), tbl[v].exp_done,
                       tbl[v].exp_err, tbl[v].exp_wc);
            if (tbl[v].exp_wc != 16'd0 && got.size() > 0) begin
                chk($sformatf("vec%0d_last_addr", v), 32'(got[$][31:16]),
                    32'(2 * (int'(tbl[v].len) - 1)));
            end
        end

        // start pulse after first word is ignored
        fill_words(16'd3, 1'b1);
        run_session(16'd3, 0, 1);
        end_checks("restart_ignored", 1'b1, 1'b0, 16'd3);

        // async reset between high and low byte of word 2
        fill_words(16'd3, 1'b1);
        got.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_rst_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_wc", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_nwrites", 32'(got.size()), 32'd1);
        fill_words(16'd2, 1'b0);
        run_session(16'd2, 0, -1);
        end_checks("after_rst", 1'b1, 1'b0, 16'd2);

        // random sessions against the model
        for (int r = 0; r < 10; r++) begin
            rlen = 16'($urandom_range(0, 70));
            ok = (rlen <= 16'd64);
            fill_words(rlen, 1'b0);
            run_session(rlen, 2, -1);
            end_checks($sformatf("rnd%0d", r), ok, !ok,
                       ok ? rlen : 16'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
